// File: rtl/div_pkg.sv
// Shared types and constants for the sequenced 32/16 divider control stage.
// Build option: DIV_SIGNED_EN enables two's-complement operand handling.
package div_pkg;

    localparam int DVD_W = 32;
    localparam int DVS_W = 16;
    localparam int Q_W   = 17;
    localparam int R_W   = 16;
    localparam int QO_W  = Q_W + 1;
    localparam int RO_W  = R_W + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        FIX    = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_SETTLE = SETTLE;
    localparam logic [1:0] ST_FIX    = FIX;
    localparam logic [1:0] ST_DONE   = DONE;

    localparam logic [QO_W-1:0] DBZ_QUOTIENT = '1;

    // Quotient needs more than Q_W bits exactly when dvd >= dvs * 2^Q_W.
    function automatic logic quot_overflow(input logic [DVD_W-1:0] dvd_mag,
                                           input logic [DVS_W-1:0] dvs_mag);
        return (dvs_mag != '0) && ((dvd_mag >> Q_W) >= DVD_W'(dvs_mag));
    endfunction

endpackage

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negate; used both to take operand magnitudes
// and to restore the sign of the quotient and remainder.
module div_sign_fix #(
    parameter int W = 16
) (
    input  logic [W-1:0] value,
    input  logic         neg,
    output logic [W-1:0] result
);

    assign result = neg ? (~value + W'(1)) : value;

endmodule

// File: rtl/div_seq_ctrl.sv
// Handshaked control stage around an external combinational 32/16 divider.
// Build option: DIV_SIGNED_EN honours in_signed; otherwise every op is unsigned.
module div_seq_ctrl
    import div_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_dividend,
    input  logic [15:0]      in_divisor,
    input  logic             in_signed,
    output logic [31:0]      div_dividend,
    output logic [15:0]      div_divisor,
    input  logic [16:0]      div_quotient,
    input  logic [15:0]      div_remainder,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [17:0]      out_quotient,
    output logic [16:0]      out_remainder,
    output logic             out_dbz,
    output logic             out_ovf
);

    logic [1:0]       state_reg;
    logic [1:0]       state_next;
    logic [3:0]       cnt_reg;
    logic [DVD_W-1:0] dvd_mag_reg;
    logic [DVS_W-1:0] dvs_mag_reg;
    logic [R_W-1:0]   dvd_lo_reg;
    logic             dbz_reg;
    logic             ovf_reg;
    logic [Q_W-1:0]   q_cap_reg;
    logic [R_W-1:0]   r_cap_reg;
    logic [QO_W-1:0]  out_q_reg;
    logic [RO_W-1:0]  out_r_reg;
    logic             out_valid_reg;
    logic             out_dbz_reg;
    logic             out_ovf_reg;

    logic [DVD_W-1:0] dvd_mag;
    logic [DVS_W-1:0] dvs_mag;
    logic [QO_W-1:0]  q_fixed;
    logic [RO_W-1:0]  r_fixed;

`ifdef DIV_SIGNED_EN
    logic sa_reg;
    logic sb_reg;
    logic dvd_neg;
    logic dvs_neg;

    assign dvd_neg = in_signed & in_dividend[DVD_W-1];
    assign dvs_neg = in_signed & in_divisor[DVS_W-1];

    div_sign_fix #(.W(DVD_W)) u_dvd_mag (
        .value  (in_dividend),
        .neg    (dvd_neg),
        .result (dvd_mag)
    );

    div_sign_fix #(.W(DVS_W)) u_dvs_mag (
        .value  (in_divisor),
        .neg    (dvs_neg),
        .result (dvs_mag)
    );

    // Quotient takes the XOR of operand signs; remainder follows the dividend.
    div_sign_fix #(.W(QO_W)) u_q_fix (
        .value  ({1'b0, q_cap_reg}),
        .neg    (sa_reg ^ sb_reg),
        .result (q_fixed)
    );

    div_sign_fix #(.W(RO_W)) u_r_fix (
        .value  ({1'b0, r_cap_reg}),
        .neg    (sa_reg),
        .result (r_fixed)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sa_reg <= 1'b0;
            sb_reg <= 1'b0;
        end else if (state_reg == ST_IDLE && in_valid) begin
            sa_reg <= dvd_neg;
            sb_reg <= dvs_neg;
        end
    end
`else
    logic unused_signed;

    assign unused_signed = in_signed;
    assign dvd_mag       = in_dividend;
    assign dvs_mag       = in_divisor;
    assign q_fixed       = {1'b0, q_cap_reg};
    assign r_fixed       = {1'b0, r_cap_reg};
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (in_valid) begin
                    // A zero divisor needs no divider result, so SETTLE is bypassed.
                    state_next = (in_divisor == '0) ? ST_FIX : ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_reg == '0) begin
                    state_next = ST_FIX;
                end
            end
            ST_FIX: begin
                state_next = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            dvd_mag_reg   <= '0;
            dvs_mag_reg   <= '0;
            dvd_lo_reg    <= '0;
            dbz_reg       <= 1'b0;
            ovf_reg       <= 1'b0;
            q_cap_reg     <= '0;
            r_cap_reg     <= '0;
            out_q_reg     <= '0;
            out_r_reg     <= '0;
            out_valid_reg <= 1'b0;
            out_dbz_reg   <= 1'b0;
            out_ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                ST_IDLE: begin
                    if (in_valid) begin
                        dvd_mag_reg <= dvd_mag;
                        dvs_mag_reg <= dvs_mag;
                        dvd_lo_reg  <= in_dividend[R_W-1:0];
                        dbz_reg     <= (in_divisor == '0);
                        ovf_reg     <= quot_overflow(dvd_mag, dvs_mag);
                        cnt_reg     <= 4'(SETTLE_CYCLES - 1);
                    end
                end
                ST_SETTLE: begin
                    if (cnt_reg != '0) begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end else begin
                        q_cap_reg <= div_quotient;
                        r_cap_reg <= div_remainder;
                    end
                end
                ST_FIX: begin
                    out_q_reg     <= dbz_reg ? DBZ_QUOTIENT : q_fixed;
                    out_r_reg     <= dbz_reg ? {1'b0, dvd_lo_reg} : r_fixed;
                    out_dbz_reg   <= dbz_reg;
                    out_ovf_reg   <= ovf_reg;
                    out_valid_reg <= 1'b1;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready      = (state_reg == ST_IDLE);
    assign div_dividend  = dvd_mag_reg;
    assign div_divisor   = dvs_mag_reg;
    assign out_valid     = out_valid_reg;
    assign out_quotient  = out_q_reg;
    assign out_remainder = out_r_reg;
    assign out_dbz       = out_dbz_reg;
    assign out_ovf       = out_ovf_reg;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed bench for div_seq_ctrl with a behavioural combinational divider attached.
// Expected values for signed ops depend on whether DIV_SIGNED_EN is defined.
`timescale 1ns/1ps
module tb_div_seq_ctrl;

`ifdef DIV_SIGNED_EN
    localparam bit SGN = 1'b1;
`else
    localparam bit SGN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_dividend;
    logic [15:0] in_divisor;
    logic        in_signed;
    logic [31:0] div_dividend;
    logic [15:0] div_divisor;
    logic [16:0] div_quotient;
    logic [15:0] div_remainder;
    logic        out_valid;
    logic        out_ready;
    logic [17:0] out_quotient;
    logic [16:0] out_remainder;
    logic        out_dbz;
    logic        out_ovf;

    int checks   = 0;
    int failures = 0;
    int lat;

    always #5 clk = ~clk;

    div_seq_ctrl #(.SETTLE_CYCLES(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_dividend   (in_dividend),
        .in_divisor    (in_divisor),
        .in_signed     (in_signed),
        .div_dividend  (div_dividend),
        .div_divisor   (div_divisor),
        .div_quotient  (div_quotient),
        .div_remainder (div_remainder),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_quotient  (out_quotient),
        .out_remainder (out_remainder),
        .out_dbz       (out_dbz),
        .out_ovf       (out_ovf)
    );

    // Behavioural unsigned divider: quotient truncated to its 17-bit port.
    always_comb begin
        div_quotient  = '0;
        div_remainder = '0;
        if (div_divisor != '0) begin
            div_quotient  = 17'(div_dividend / {16'd0, div_divisor});
            div_remainder = 16'(div_dividend % {16'd0, div_divisor});
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_res(input string tag, input logic [17:0] q, input logic [16:0] r,
                           input logic dbz, input logic ovf);
        $display("op %s: q=0x%05h r=0x%05h dbz=%0b ovf=%0b", tag, out_quotient,
                 out_remainder, out_dbz, out_ovf);
        chk({tag, ".q"}, out_quotient, q);
        chk({tag, ".r"}, out_remainder, r);
        chk({tag, ".dbz"}, out_dbz, dbz);
        chk({tag, ".ovf"}, out_ovf, ovf);
    endtask

    // Issue one op; lat counts edges after the accept edge until out_valid is seen.
    task automatic do_op(input logic [31:0] dvd, input logic [15:0] dvs, input logic sgn,
                         output int l);
        int guard;
        in_dividend = dvd;
        in_divisor  = dvs;
        in_signed   = sgn;
        in_valid    = 1'b1;
        guard = 0;
        while (!in_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        l = 0;
        while (!out_valid && l < 20) begin
            @(posedge clk); #1;
            l++;
        end
    endtask

    task automatic take_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_dividend = '0;
        in_divisor  = '0;
        in_signed   = 1'b0;
        out_ready   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.in_ready", in_ready, 1);
        chk("rst.out_valid", out_valid, 0);
        chk("rst.q", out_quotient, 0);
        chk("rst.r", out_remainder, 0);
        chk("rst.dbz", out_dbz, 0);
        chk("rst.ovf", out_ovf, 0);
        chk("rst.div_dividend", div_dividend, 0);
        chk("rst.div_divisor", div_divisor, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Unsigned 100/7; out_valid in cycle SETTLE_CYCLES+2 counting the accept cycle as 0.
        do_op(32'd100, 16'd7, 1'b0, lat);
        chk("u100_7.lat", lat, 3);
        chk_res("u100_7", 18'd14, 17'd2, 1'b0, 1'b0);
        chk("u100_7.in_ready_done", in_ready, 0);
        take_result();
        chk("u100_7.valid_drop", out_valid, 0);
        chk("u100_7.in_ready_idle", in_ready, 1);

        // Signed -100/7 (unsigned build: huge dividend overflows, divider values pass through).
        do_op(32'hFFFF_FF9C, 16'd7, 1'b1, lat);
        chk_res("s-100_7", SGN ? 18'h3FFF2 : 18'h04916, SGN ? 17'h1FFFE : 17'h00002,
                1'b0, SGN ? 1'b0 : 1'b1);
        chk("s-100_7.div_dividend", div_dividend, SGN ? 32'd100 : 32'hFFFF_FF9C);
        take_result();

        // Signed 100/-7
        do_op(32'd100, 16'hFFF9, 1'b1, lat);
        chk_res("s100_-7", SGN ? 18'h3FFF2 : 18'h0, SGN ? 17'd2 : 17'd100, 1'b0, 1'b0);
        chk("s100_-7.div_divisor", div_divisor, SGN ? 16'd7 : 16'hFFF9);
        take_result();

        // Divide by zero: SETTLE bypassed, result one edge after accept.
        do_op(32'h1234_5678, 16'd0, 1'b0, lat);
        chk("dbz.lat", lat, 1);
        chk_res("dbz", 18'h3FFFF, 17'h05678, 1'b1, 1'b0);
        take_result();

        // Overflow: divider quotient is truncated 0x00FF0000 -> 0x10000.
        do_op(32'h00FF_0000, 16'd1, 1'b0, lat);
        chk_res("ovf", 18'h10000, 17'd0, 1'b0, 1'b1);
        take_result();

        // Largest non-overflowing quotient.
        do_op(32'h0001_FFFF, 16'd1, 1'b0, lat);
        chk_res("qmax", 18'h1FFFF, 17'd0, 1'b0, 1'b0);
        take_result();

        // Extreme operands: -2^31 / -2^15 = 2^16 (unsigned build: 2^31 / 2^15, same).
        do_op(32'h8000_0000, 16'h8000, 1'b1, lat);
        chk_res("extreme", 18'h10000, 17'd0, 1'b0, 1'b0);
        chk("extreme.div_dividend", div_dividend, 32'h8000_0000);
        chk("extreme.div_divisor", div_divisor, 16'h8000);

        // Hold in DONE with out_ready low while a new request waits.
        in_dividend = 32'd7;
        in_divisor  = 16'd2;
        in_signed   = 1'b0;
        in_valid    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("hold.valid", out_valid, 1);
            chk("hold.q", out_quotient, 18'h10000);
            chk("hold.in_ready", in_ready, 0);
        end
        take_result();
        chk("release.valid", out_valid, 0);
        chk("release.in_ready", in_ready, 1);
        @(posedge clk); #1;
        chk("release.accepted", in_ready, 0);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("u7_2.lat", lat, 3);
        chk_res("u7_2", 18'd3, 17'd1, 1'b0, 1'b0);
        take_result();

        // Reset pulse while in SETTLE.
        in_dividend = 32'd1000;
        in_divisor  = 16'd3;
        in_signed   = 1'b0;
        in_valid    = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("midrst.out_valid", out_valid, 0);
        chk("midrst.in_ready", in_ready, 1);
        chk("midrst.div_dividend", div_dividend, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("midrst.no_result", out_valid, 0);
        do_op(32'd1000, 16'd3, 1'b0, lat);
        chk("after_rst.lat", lat, 3);
        chk_res("after_rst", 18'd333, 17'd1, 1'b0, 1'b0);
        take_result();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
